cc1200_spi_slave: RTL
=====================

CC1200_SPI_SLAVE -- requirements
Module: cc1200_spi_slave

Interface
REQ-001 SHALL have parameter REG_INIT, default 8'h00: reset value of all 64 register-file entries.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for SCLK, MOSI and CS_n; legal values 2..3.
REQ-003 SHALL have port clk  input  1  block clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SCLK  input  1  SPI clock from the master (mode 0: CPOL=0, CPHA=0).
REQ-006 SHALL have port MOSI  input  1  serial data from the master, MSB first.
REQ-007 SHALL have port MISO  output  1  serial data to the master, MSB first.
REQ-008 SHALL have port CS_n  input  1  chip select, active-low.
REQ-009 SHALL have port Status  input  3  chip-state field returned in the status byte.
REQ-010 SHALL have port Busy  output  1  high while a transaction is in progress (CS_n synchronised low).
REQ-011 SHALL have port WrStrobe  output  1  one-clk pulse per committed register write.
REQ-012 SHALL have port WrAddr  output  6  address of the current write; valid while WrStrobe is high.
REQ-013 SHALL have port WrData  output  8  data of the current write; valid while WrStrobe is high.
REQ-014 SHALL have port DbgAddr  input  6  register-file debug read address.
REQ-015 SHALL have port DbgData  output  8  combinational read of reg[DbgAddr].

Function
REQ-016 SHALL pass SCLK, MOSI and CS_n through SYNC_STAGES flops, then detect edges from the last two stages; clk SHALL run at least 4x SCLK.
REQ-017 SHALL implement the states IDLE, HDR and DATA; CS_n falling moves IDLE->HDR; CS_n rising from any state moves to IDLE on the next clk.
REQ-018 SHALL sample MOSI on each synchronised SCLK rising edge and count bits with a 3-bit counter that wraps 7->0.
REQ-019 SHALL latch the header on the 8th rising edge in HDR as bit7=R/W (1=read), bit6=burst, bits5:0=address, then move to DATA.
REQ-020 SHALL load the status byte {1'b0, Status, 4'h0} into the transmit shifter on CS_n falling, with its MSB on MISO within SYNC_STAGES+1 clk.
REQ-021 SHALL shift MISO on each synchronised SCLK falling edge, updating it within SYNC_STAGES+1 clk of the pin edge.
REQ-022 Read: reg[addr] SHALL be loaded into the shifter before the first falling edge of each data byte; for burst, reg[addr+1] is loaded for the next byte.
REQ-023 Write: on the 8th rising edge of each data byte SHALL write reg[addr] and pulse WrStrobe for 1 clk with WrAddr=addr and WrData=byte.
REQ-024 Address arithmetic SHALL be 6-bit modulo: after address 63 the next address is 0.
REQ-025 Single access (burst=0): SHALL process exactly one data byte; later bytes are ignored (no write, MISO=0) until CS_n rises.
REQ-026 CS_n rising mid-byte SHALL discard the partial byte (no write, no strobe) and reset the bit counter.
REQ-027 MISO SHALL be 0 whenever CS_n is synchronised high.
REQ-028 A write and a DbgAddr read of the same entry in the same clk SHALL return the old value; the new value is visible from the next clk.

Reset
REQ-029 On rstn low: state=IDLE, counter=0, shifters=0, MISO=0, Busy=0, WrStrobe=0, WrAddr=0, WrData=0, synchronisers=1 for CS_n and 0 for SCLK and MOSI, all registers=REG_INIT.
REQ-030 Reset asserted mid-transaction SHALL abort it with no write; after release the block waits for a fresh CS_n falling edge.

Configuration
REQ-031 Macro CC1200_SPI_SLV_BURST_EN defined: the burst bit is honoured per REQ-022 to REQ-024.
REQ-032 Macro CC1200_SPI_SLV_BURST_EN undefined: the burst bit is ignored and every access behaves per REQ-025.

Verification
REQ-033 Reset, then idle -> MISO=0, Busy=0, WrStrobe=0, DbgData=8'h00 for DbgAddr=0..63.
REQ-034 Status=3'd1, header 8'h05, data 8'hA5 -> MISO header byte 8'h10; one WrStrobe with WrAddr=6'h05, WrData=8'hA5; reg[5]=8'hA5.
REQ-035 After REQ-034, header 8'h85 with 8 dummy clocks -> MISO data byte 8'hA5; no WrStrobe.
REQ-036 BURST_EN defined, header 8'h7E, data 11,22,33 -> reg[3E]=11, reg[3F]=22, reg[00]=33 (wrap); 3 strobes. Undefined -> only reg[3E]=11; 1 strobe.
REQ-037 Header 8'h02, then CS_n rises after 4 data bits -> no WrStrobe, reg[2] unchanged; next transaction to 8'h02 with data 8'h5A writes correctly.
REQ-038 rstn pulsed low during the data byte of a write -> no strobe, register keeps REG_INIT, MISO=0.

Source files
------------

// File: rtl/cc1200_spi_slave.sv
// cc1200_spi_slave: CC1200-style SPI mode-0 slave with a 64x8 register file.
// Ports: clk/rstn (async active-low) block clock and reset; SCLK/MOSI/CS_n/MISO SPI pins;
// Status chip state returned in the status byte; Busy transaction in progress;
// WrStrobe/WrAddr/WrData one-clk write notification; DbgAddr/DbgData combinational register read.
// Macro CC1200_SPI_SLV_BURST_EN: when defined the header burst bit enables auto-incrementing bursts.
module cc1200_spi_slave #(
  parameter logic [7:0] REG_INIT    = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       CS_n,
  input  logic [2:0] Status,
  output logic       Busy,
  output logic       WrStrobe,
  output logic [5:0] WrAddr,
  output logic [7:0] WrData,
  input  logic [5:0] DbgAddr,
  output logic [7:0] DbgData
);
  localparam int N = SYNC_STAGES;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_nxt;
  logic [N-1:0] sclk_s, mosi_s, cs_s;
  logic started, armed, rw, done;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] tx;
  logic [5:0] addr;
  logic [7:0] regs [64];
  logic cs_hi, cs_fall, s_rise, s_fall, act, last, more;
  logic [7:0] byte_in;
`ifdef CC1200_SPI_SLV_BURST_EN
  logic burst;
  assign more = burst;
`else
  assign more = 1'b0;
`endif
  // armed only rises once CS_n has been seen high after reset, so a CS_n held
  // low through reset cannot fake a falling edge out of the reset-high chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_s  <= '0;
      mosi_s  <= '0;
      cs_s    <= '1;
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sclk_s  <= {sclk_s[N-2:0], SCLK};
      mosi_s  <= {mosi_s[N-2:0], MOSI};
      cs_s    <= {cs_s[N-2:0], CS_n};
      started <= 1'b1;
      armed   <= armed | (started & cs_s[0]);
    end
  end
  assign cs_hi   = cs_s[N-2];
  assign cs_fall = ~cs_s[N-2] & cs_s[N-1] & armed;
  assign s_rise  = sclk_s[N-2] & ~sclk_s[N-1];
  assign s_fall  = ~sclk_s[N-2] & sclk_s[N-1];
  assign act     = (state != IDLE) & ~cs_hi;
  assign last    = s_rise & (cnt == 3'd7);
  assign byte_in = {rx, mosi_s[N-1]};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = cs_fall ? HDR : IDLE;
    else if (cs_hi) state_nxt = IDLE;
    else if (state == HDR && last) state_nxt = DATA;
  end
  // The next byte replaces the shift on the falling edge that ends a byte
  // (counter back at 0), so its MSB is on MISO before the next rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= 3'd0;
      rx       <= 7'd0;
      tx       <= 8'h00;
      addr     <= 6'd0;
      rw       <= 1'b0;
      done     <= 1'b0;
      WrStrobe <= 1'b0;
      WrAddr   <= 6'd0;
      WrData   <= 8'h00;
`ifdef CC1200_SPI_SLV_BURST_EN
      burst    <= 1'b0;
`endif
    end else begin
      WrStrobe <= 1'b0;
      if (state == IDLE) begin
        cnt  <= 3'd0;
        rx   <= 7'd0;
        tx   <= cs_fall ? {1'b0, Status, 4'h0} : 8'h00;
        done <= 1'b0;
      end else if (cs_hi) begin
        cnt <= 3'd0;
        rx  <= 7'd0;
        tx  <= 8'h00;
      end else begin
        if (s_rise) begin
          cnt <= cnt + 3'd1;
          rx  <= byte_in[6:0];
        end
        if (last && state == HDR) begin
          rw    <= byte_in[7];
          addr  <= byte_in[5:0];
`ifdef CC1200_SPI_SLV_BURST_EN
          burst <= byte_in[6];
`endif
        end
        if (last && state == DATA) begin
          if (!done && !rw) begin
            WrStrobe <= 1'b1;
            WrAddr   <= addr;
            WrData   <= byte_in;
          end
          if (more) addr <= addr + 6'd1;
          else done <= 1'b1;
        end
        if (s_fall) tx <= (state == DATA && cnt == 3'd0) ? ((rw && !done) ? regs[addr] : 8'h00) : {tx[6:0], 1'b0};
      end
    end
  end
  // The register commits at the end of the strobe cycle, so a debug read
  // during the strobe still shows the old contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) for (int i = 0; i < 64; i++) regs[i] <= REG_INIT;
    else if (WrStrobe) regs[WrAddr] <= WrData;
  end
  assign Busy    = state != IDLE;
  assign MISO    = act & tx[7];
  assign DbgData = regs[DbgAddr];
endmodule
